// File: rtl/inv_cipher_iter.sv
// inv_cipher_iter: iterative AES-128/192/256 inverse cipher, one round per clock.
// Optional INV_CIPHER_KEY_LATCH_EN copies the key schedule at start so words may change mid-block.
module inv_shift_rows (
    input  logic [0:127] d,
    output logic [0:127] q
);
    for (genvar c = 0; c < 4; c++) begin : g_col
        for (genvar r = 0; r < 4; r++) begin : g_row
            assign q[8*(4*c+r) +: 8] = d[8*(4*((c-r+4)%4)+r) +: 8];
        end
    end
endmodule

module inv_sub_bytes (
    input  logic [0:127] d,
    output logic [0:127] q
);
    localparam logic [0:2047] ISB = {
        128'h52096ad53036a538bf40a39e81f3d7fb, 128'h7ce339829b2fff87348e4344c4dee9cb,
        128'h547b9432a6c2233dee4c950b42fac34e, 128'h082ea16628d924b2765ba2496d8bd125,
        128'h72f8f66486689816d4a45ccc5d65b692, 128'h6c704850fdedb9da5e154657a78d9d84,
        128'h90d8ab008cbcd30af7e45805b8b34506, 128'hd02c1e8fca3f0f02c1afbd0301138a6b,
        128'h3a9111414f67dcea97f2cfcef0b4e673, 128'h96ac7422e7ad3585e2f937e81c75df6e,
        128'h47f11a711d29c5896fb7620eaa18be1b, 128'hfc563e4bc6d279209adbc0fe78cd5af4,
        128'h1fdda8338807c731b11210592780ec5f, 128'h60517fa919b54a0d2de57a9f93c99cef,
        128'ha0e03b4dae2af5b0c8ebbb3c83539961, 128'h172b047eba77d626e169146355210c7d};
    for (genvar i = 0; i < 16; i++) begin : g_byte
        assign q[8*i +: 8] = ISB[{d[8*i +: 8], 3'b000} +: 8];
    end
endmodule

module inv_mix_columns (
    input  logic [0:127] d,
    output logic [0:127] q
);
    function automatic logic [7:0] xt(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction
    function automatic logic [7:0] mul(input logic [7:0] b, input logic [3:0] m);
        logic [7:0] b2, b4, b8;
        b2 = xt(b);
        b4 = xt(b2);
        b8 = xt(b4);
        return (m[0] ? b : 8'h00) ^ (m[1] ? b2 : 8'h00) ^ (m[2] ? b4 : 8'h00) ^ (m[3] ? b8 : 8'h00);
    endfunction
    for (genvar c = 0; c < 4; c++) begin : g_col
        logic [7:0] a0, a1, a2, a3;
        assign {a0, a1, a2, a3} = d[32*c +: 32];
        assign q[32*c      +: 8] = mul(a0, 4'd14) ^ mul(a1, 4'd11) ^ mul(a2, 4'd13) ^ mul(a3, 4'd9);
        assign q[32*c + 8  +: 8] = mul(a0, 4'd9)  ^ mul(a1, 4'd14) ^ mul(a2, 4'd11) ^ mul(a3, 4'd13);
        assign q[32*c + 16 +: 8] = mul(a0, 4'd13) ^ mul(a1, 4'd9)  ^ mul(a2, 4'd14) ^ mul(a3, 4'd11);
        assign q[32*c + 24 +: 8] = mul(a0, 4'd11) ^ mul(a1, 4'd13) ^ mul(a2, 4'd9)  ^ mul(a3, 4'd14);
    end
endmodule

module add_round_key (
    input  logic [0:127] d,
    input  logic [0:127] k,
    output logic [0:127] q
);
    assign q = d ^ k;
endmodule

module inv_cipher_iter #(
    parameter int x = 0
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start,
    input  logic [0:127]              in,
    input  logic [0:128*(11+2*x)-1]   words,
    output logic [0:127]              out,
    output logic                      busy,
    output logic                      done
);
    localparam int NR = 10 + 2*x;
    localparam int KW = 128*(NR+1);
    typedef enum logic [1:0] {IDLE, RUN, FINAL} state_t;
    state_t state, state_nx;
    logic [3:0] rnd, ki;
    logic [0:127] st, rk, isr, isb, ark, imc, ark_in;
    logic [0:KW-1] kw;
`ifdef INV_CIPHER_KEY_LATCH_EN
    logic [0:KW-1] key_q;
    always_ff @(posedge clk) begin
        if (rst) key_q <= '0;
        else if (state == IDLE && start) key_q <= words;
    end
    // The copy is not loaded until E0, so the initial whitening key comes straight from words.
    assign kw = (state == IDLE) ? words : key_q;
`else
    assign kw = words;
`endif
    assign ki = (state == IDLE) ? 4'(NR) : rnd;
    assign rk = kw[128*ki +: 128];
    add_round_key   u_ark_in (.d(in),  .k(rk), .q(ark_in));
    inv_shift_rows  u_isr    (.d(st),  .q(isr));
    inv_sub_bytes   u_isb    (.d(isr), .q(isb));
    add_round_key   u_ark    (.d(isb), .k(rk), .q(ark));
    inv_mix_columns u_imc    (.d(ark), .q(imc));
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else state <= state_nx;
    end
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    state_nx = start ? RUN : IDLE;
            RUN:     state_nx = (rnd == 4'd1) ? FINAL : RUN;
            default: state_nx = IDLE;
        endcase
    end
    always_comb begin
        busy = (state != IDLE);
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            st   <= '0;
            rnd  <= '0;
            out  <= '0;
            done <= 1'b0;
        end else begin
            done <= (state == FINAL);
            if (state == IDLE && start) begin
                st  <= ark_in;
                rnd <= 4'(NR-1);
            end else if (state == RUN) begin
                st  <= imc;
                rnd <= rnd - 4'd1;
            end else if (state == FINAL) begin
                out <= ark;
            end
        end
    end
endmodule

// File: tb/tb_inv_cipher_iter.sv
// tb_inv_cipher_iter: directed FIPS-197 vectors for all three key sizes plus handshake corner cases.
module tb_inv_cipher_iter;
    localparam logic [0:127] PT  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [0:127] CT0 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [0:127] CT1 = 128'hdda97ca4864cdfe06eaf70a0ec0d7191;
    localparam logic [0:127] CT2 = 128'h8ea2b7ca516745bfeafc49904b496089;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic start_v [3];
    logic [0:127] in_v [3];
    logic [0:127] out_v [3];
    logic busy_v [3];
    logic done_v [3];
    logic [0:1407] w0;
    logic [0:1663] w1;
    logic [0:1919] w2;
    int n_vec = 0;
    int n_err = 0;
    always #5 clk = ~clk;
    inv_cipher_iter #(.x(0)) u_dut0 (.clk(clk), .rst(rst), .start(start_v[0]), .in(in_v[0]), .words(w0),
                                     .out(out_v[0]), .busy(busy_v[0]), .done(done_v[0]));
    inv_cipher_iter #(.x(1)) u_dut1 (.clk(clk), .rst(rst), .start(start_v[1]), .in(in_v[1]), .words(w1),
                                     .out(out_v[1]), .busy(busy_v[1]), .done(done_v[1]));
    inv_cipher_iter #(.x(2)) u_dut2 (.clk(clk), .rst(rst), .start(start_v[2]), .in(in_v[2]), .words(w2),
                                     .out(out_v[2]), .busy(busy_v[2]), .done(done_v[2]));

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h want %h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        for (int i = 0; i < 8; i++) begin
            if (b[0]) p ^= a;
            a = {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
            b = b >> 1;
        end
        return p;
    endfunction

    // Forward S-box from its algebraic definition: GF(2^8) inverse then affine map.
    function automatic logic [7:0] sbox(input logic [7:0] b);
        logic [7:0] inv = 8'h01;
        logic [7:0] r, s;
        if (b == 8'h00) inv = 8'h00;
        else for (int i = 0; i < 254; i++) inv = gmul(inv, b);
        r = inv;
        s = inv;
        for (int k = 0; k < 4; k++) begin
            r = {r[6:0], r[7]};
            s ^= r;
        end
        return s ^ 8'h63;
    endfunction

    function automatic logic [31:0] subw(input logic [31:0] t);
        return {sbox(t[31:24]), sbox(t[23:16]), sbox(t[15:8]), sbox(t[7:0])};
    endfunction

    // Key schedule for key bytes 00,01,02,... of nk words.
    function automatic logic [0:1919] expand(input int nk);
        logic [31:0] w [60];
        logic [31:0] t;
        logic [7:0] rc = 8'h01;
        logic [0:1919] r = '0;
        int nw = 4*(nk+7);
        for (int i = 0; i < nk; i++) w[i] = {8'(4*i), 8'(4*i+1), 8'(4*i+2), 8'(4*i+3)};
        for (int i = nk; i < nw; i++) begin
            t = w[i-1];
            if (i % nk == 0) begin
                t = subw({t[23:0], t[31:24]}) ^ {rc, 24'h0};
                rc = gmul(rc, 8'h02);
            end else if (nk > 6 && i % nk == 4) t = subw(t);
            w[i] = w[i-nk] ^ t;
        end
        for (int i = 0; i < nw; i++) r[32*i +: 32] = w[i];
        return r;
    endfunction

    task automatic run_blk(input int sel, input logic [0:127] ct, input bit corrupt,
                           output int lat, output int bcnt, output logic [0:127] res);
        start_v[sel] = 1'b1;
        in_v[sel] = ct;
        @(posedge clk);
        #1;
        start_v[sel] = 1'b0;
        in_v[sel] = '1;
        if (corrupt) w0 = '1;
        lat = 0;
        bcnt = int'(busy_v[sel]);
        while (lat < 40) begin
            @(posedge clk);
            #1;
            lat++;
            if (done_v[sel]) break;
            bcnt += int'(busy_v[sel]);
        end
        res = out_v[sel];
    endtask

    initial begin
        logic [0:1919] ek;
        logic [0:127] res;
        int lat, bc, nd, dlat;
        for (int i = 0; i < 3; i++) begin
            start_v[i] = 1'b0;
            in_v[i] = '0;
        end
        ek = expand(4); w0 = ek[0:1407];
        ek = expand(6); w1 = ek[0:1663];
        ek = expand(8); w2 = ek;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        chk("rst_busy", 128'(busy_v[0]), 128'd0);
        chk("rst_done", 128'(done_v[0]), 128'd0);
        chk("rst_out", out_v[0], 128'd0);

        run_blk(0, CT0, 1'b0, lat, bc, res);
        chk("t1_latency", 128'(lat), 128'd10);
        chk("t1_out", res, PT);
        chk("t1_busy_cycles", 128'(bc), 128'd10);
        chk("t1_busy_at_done", 128'(busy_v[0]), 128'd0);
        run_blk(0, CT0, 1'b0, lat, bc, res);
        chk("b2b_latency", 128'(lat), 128'd10);
        chk("b2b_out", res, PT);
        @(posedge clk);
        #1;
        chk("done_one_cycle", 128'(done_v[0]), 128'd0);
        chk("out_held", out_v[0], PT);

        run_blk(1, CT1, 1'b0, lat, bc, res);
        chk("t2_latency", 128'(lat), 128'd12);
        chk("t2_out", res, PT);
        run_blk(2, CT2, 1'b0, lat, bc, res);
        chk("t3_latency", 128'(lat), 128'd14);
        chk("t3_out", res, PT);

        start_v[0] = 1'b1;
        in_v[0] = CT0;
        @(posedge clk);
        #1;
        start_v[0] = 1'b0;
        in_v[0] = CT1;
        nd = 0;
        dlat = 0;
        for (int k = 1; k <= 12; k++) begin
            start_v[0] = (k == 3 || k == 7);
            @(posedge clk);
            #1;
            if (done_v[0]) begin
                nd++;
                dlat = k;
            end
        end
        start_v[0] = 1'b0;
        chk("t4_done_count", 128'(nd), 128'd1);
        chk("t4_latency", 128'(dlat), 128'd10);
        chk("t4_out", out_v[0], PT);

        start_v[0] = 1'b1;
        in_v[0] = CT0;
        @(posedge clk);
        #1;
        start_v[0] = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        chk("t5_busy", 128'(busy_v[0]), 128'd0);
        chk("t5_done", 128'(done_v[0]), 128'd0);
        chk("t5_out", out_v[0], 128'd0);
        nd = 0;
        repeat (15) begin
            @(posedge clk);
            #1;
            nd += int'(done_v[0]);
        end
        chk("t5_no_done", 128'(nd), 128'd0);
        run_blk(0, CT0, 1'b0, lat, bc, res);
        chk("t5_latency", 128'(lat), 128'd10);
        chk("t5_out_after", res, PT);

        run_blk(0, CT0, 1'b1, lat, bc, res);
        ek = expand(4);
        w0 = ek[0:1407];
        chk("t6_latency", 128'(lat), 128'd10);
`ifdef INV_CIPHER_KEY_LATCH_EN
        chk("t6_latched_out", res, PT);
`else
        $display("note: t6 without key latch, out=%h (differs from plaintext: %0d)", res, res != PT);
`endif
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
